// File: rtl/decode_pkg.sv
// Shared widths, default field offsets and the decoded-instruction record for decode_stage.
// The defaults describe the r/rs/rd/func/imm layout; rt overlays the top of imm.
package decode_pkg;

    localparam int DEF_INSTR_W  = 32;
    localparam int DEF_REG_AW   = 6;
    localparam int DEF_FUNC_W   = 4;
    localparam int DEF_IMM_W    = 15;
    localparam int DEF_DATA_W   = 32;
    localparam int DEF_SB_DEPTH = 4;

    localparam int R_POS    = DEF_INSTR_W - 1;
    localparam int RS_MSB   = R_POS - 1;
    localparam int RD_MSB   = RS_MSB - DEF_REG_AW;
    localparam int FUNC_MSB = RD_MSB - DEF_REG_AW;
    localparam int RT_MSB   = DEF_IMM_W - 1;

    typedef struct packed {
        logic                    r;
        logic [DEF_REG_AW-1:0]   rs;
        logic [DEF_REG_AW-1:0]   rd;
        logic [DEF_REG_AW-1:0]   rt;
        logic [DEF_FUNC_W-1:0]   func;
        logic [DEF_DATA_W-1:0]   imm;
        logic                    write_en;
    } decoded_instr_t;

    // Register 0 is hardwired, so it never counts as a write target.
    function automatic decoded_instr_t extract_fields(
        input logic [DEF_INSTR_W-1:0] instr,
        input logic                   write_disable
    );
        decoded_instr_t d;
        d.r        = instr[R_POS];
        d.rs       = instr[RS_MSB -: DEF_REG_AW];
        d.rd       = instr[RD_MSB -: DEF_REG_AW];
        d.func     = instr[FUNC_MSB -: DEF_FUNC_W];
        d.rt       = instr[RT_MSB -: DEF_REG_AW];
        d.imm      = {{(DEF_DATA_W-DEF_IMM_W){instr[DEF_IMM_W-1]}}, instr[DEF_IMM_W-1:0]};
        d.write_en = !write_disable && (d.rd != '0);
        return d;
    endfunction

endpackage

// File: rtl/decode_scoreboard.sv
// In-order FIFO of pending destination registers with parallel two-source match.
// Matches ignore the head entry when it is being popped this cycle.
module decode_scoreboard
    import decode_pkg::*;
#(
    parameter int REG_AW   = DEF_REG_AW,
    parameter int SB_DEPTH = DEF_SB_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [REG_AW-1:0] push_addr,
    input  logic              pop,
    input  logic [REG_AW-1:0] src_a,
    input  logic [REG_AW-1:0] src_b,
    output logic              match_a,
    output logic              match_b,
    output logic              full,
    output logic              empty
);

    localparam int PTR_W = $clog2(SB_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [REG_AW-1:0] entry_mem [SB_DEPTH];
    logic [PTR_W-1:0]  head_reg, head_next;
    logic [PTR_W-1:0]  tail_reg, tail_next;
    logic [CNT_W-1:0]  count_reg, count_next;
    logic              pop_eff, push_eff;
    logic [SB_DEPTH-1:0] live, hit_a, hit_b;

    assign full     = (count_reg == CNT_W'(SB_DEPTH));
    assign empty    = (count_reg == '0);
    assign pop_eff  = pop && !empty;
    // A push into a full FIFO is only legal when the head leaves the same cycle.
    assign push_eff = push && (!full || pop_eff);

    generate
        for (genvar gi = 0; gi < SB_DEPTH; gi++) begin : g_entry
            logic [PTR_W-1:0] age;
            assign age       = PTR_W'(gi) - head_reg;
            assign live[gi]  = ({1'b0, age} < count_reg) && !(pop_eff && (age == '0));
            assign hit_a[gi] = live[gi] && (entry_mem[gi] == src_a);
            assign hit_b[gi] = live[gi] && (entry_mem[gi] == src_b);
        end
    endgenerate

    assign match_a = |hit_a;
    assign match_b = |hit_b;

    always_comb begin
        head_next  = head_reg + PTR_W'(pop_eff);
        tail_next  = tail_reg + PTR_W'(push_eff);
        count_next = count_reg + CNT_W'(push_eff) - CNT_W'(pop_eff);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
        end else begin
            head_reg  <= head_next;
            tail_reg  <= tail_next;
            count_reg <= count_next;
        end
    end

    // Stale contents after reset are harmless: nothing is live until pushed.
    always_ff @(posedge clk) begin
        if (push_eff) begin
            entry_mem[tail_reg] <= push_addr;
        end
    end

endmodule

// File: rtl/decode_stage.sv
// Registered instruction-decode stage with valid/ready on both sides and a write-enable gate.
// Define DECODE_SCOREBOARD_EN to add the pending-write scoreboard and hazard stall.
module decode_stage
    import decode_pkg::*;
#(
    parameter int INSTR_W  = DEF_INSTR_W,
    parameter int REG_AW   = DEF_REG_AW,
    parameter int FUNC_W   = DEF_FUNC_W,
    parameter int IMM_W    = DEF_IMM_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int SB_DEPTH = DEF_SB_DEPTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic               write_disable,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               out_r,
    output logic [REG_AW-1:0]  out_rs,
    output logic [REG_AW-1:0]  out_rd,
    output logic [FUNC_W-1:0]  out_func,
    output logic [REG_AW-1:0]  out_rt,
    output logic [DATA_W-1:0]  out_imm,
    output logic               out_write_en,
    input  logic               wb_valid,
    output logic               hazard
);

    localparam int RS_HI   = INSTR_W - 2;
    localparam int RD_HI   = RS_HI - REG_AW;
    localparam int FUNC_HI = RD_HI - REG_AW;

    logic              dec_r;
    logic [REG_AW-1:0] dec_rs, dec_rd, dec_rt;
    logic [FUNC_W-1:0] dec_func;
    logic [DATA_W-1:0] dec_imm;
    logic              dec_we;
    logic              accept;

    logic              out_valid_reg;
    logic              out_r_reg;
    logic [REG_AW-1:0] out_rs_reg, out_rd_reg, out_rt_reg;
    logic [FUNC_W-1:0] out_func_reg;
    logic [DATA_W-1:0] out_imm_reg;
    logic              out_we_reg;

    assign dec_r    = in_instr[INSTR_W-1];
    assign dec_rs   = in_instr[RS_HI -: REG_AW];
    assign dec_rd   = in_instr[RD_HI -: REG_AW];
    assign dec_func = in_instr[FUNC_HI -: FUNC_W];
    assign dec_rt   = in_instr[IMM_W-1 -: REG_AW];
    assign dec_imm  = {{(DATA_W-IMM_W){in_instr[IMM_W-1]}}, in_instr[IMM_W-1:0]};
    assign dec_we   = !write_disable && (dec_rd != '0);

    assign accept = in_valid && in_ready;

`ifdef DECODE_SCOREBOARD_EN
    logic match_rs, match_rt, sb_full, sb_empty_unused;

    decode_scoreboard #(
        .REG_AW   (REG_AW),
        .SB_DEPTH (SB_DEPTH)
    ) u_scoreboard (
        .clk       (clk),
        .rst       (rst),
        .push      (accept && dec_we),
        .push_addr (dec_rd),
        .pop       (wb_valid),
        .src_a     (dec_rs),
        .src_b     (dec_rt),
        .match_a   (match_rs),
        .match_b   (match_rt),
        .full      (sb_full),
        .empty     (sb_empty_unused)
    );

    // I-type instructions only read rs; register 0 can never be pending.
    assign hazard = in_valid &&
                    (((dec_rs != '0) && match_rs) ||
                     (dec_r && (dec_rt != '0) && match_rt) ||
                     (dec_we && sb_full && !wb_valid));
    assign in_ready = (!out_valid_reg || out_ready) && !hazard;
`else
    localparam int SB_DEPTH_UNUSED = SB_DEPTH;
    logic wb_valid_unused;

    assign wb_valid_unused = wb_valid;
    assign hazard          = 1'b0;
    assign in_ready        = !out_valid_reg || out_ready;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_reg <= 1'b0;
            out_r_reg     <= 1'b0;
            out_rs_reg    <= '0;
            out_rd_reg    <= '0;
            out_rt_reg    <= '0;
            out_func_reg  <= '0;
            out_imm_reg   <= '0;
            out_we_reg    <= 1'b0;
        end else if (accept) begin
            out_valid_reg <= 1'b1;
            out_r_reg     <= dec_r;
            out_rs_reg    <= dec_rs;
            out_rd_reg    <= dec_rd;
            out_rt_reg    <= dec_rt;
            out_func_reg  <= dec_func;
            out_imm_reg   <= dec_imm;
            out_we_reg    <= dec_we;
        end else if (out_ready) begin
            out_valid_reg <= 1'b0;
        end
    end

    assign out_valid    = out_valid_reg;
    assign out_r        = out_r_reg;
    assign out_rs       = out_rs_reg;
    assign out_rd       = out_rd_reg;
    assign out_rt       = out_rt_reg;
    assign out_func     = out_func_reg;
    assign out_imm      = out_imm_reg;
    assign out_write_en = out_we_reg;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage with a queue-based reference model checked every cycle.
// Follows the DUT build: scoreboard behaviour is expected only with DECODE_SCOREBOARD_EN.
module tb_decode_stage;

`ifdef DECODE_SCOREBOARD_EN
    localparam bit SB_EN = 1'b1;
`else
    localparam bit SB_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, write_disable, out_valid, out_ready;
    logic        out_r, out_write_en, wb_valid, hazard;
    logic [31:0] in_instr, out_imm;
    logic [5:0]  out_rs, out_rd, out_rt;
    logic [3:0]  out_func;

    int n_total = 0;
    int n_pass  = 0;

    // reference model state
    bit          m_valid, m_r, m_we;
    int          m_rs, m_rd, m_rt, m_func;
    logic [31:0] m_imm;
    int          pend[$];

    // per-cycle scratch for the compare process
    bit          f_r, f_we, c_pop, c_haz, c_rdy;
    int          f_rs, f_rd, f_rt, f_func;
    logic [31:0] f_imm;

    always #5 clk = ~clk;

    decode_stage dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_instr      (in_instr),
        .write_disable (write_disable),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_r         (out_r),
        .out_rs        (out_rs),
        .out_rd        (out_rd),
        .out_func      (out_func),
        .out_rt        (out_rt),
        .out_imm       (out_imm),
        .out_write_en  (out_write_en),
        .wb_valid      (wb_valid),
        .hazard        (hazard)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    function automatic bit pending_hit(int src, bit popping);
        if (src == 0) return 1'b0;
        foreach (pend[i]) begin
            if (!(popping && i == 0) && pend[i] == src) return 1'b1;
        end
        return 1'b0;
    endfunction

    // Compare on the falling edge; inputs are stable here until the next rising edge.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                m_valid = 0; m_r = 0; m_we = 0;
                m_rs = 0; m_rd = 0; m_rt = 0; m_func = 0; m_imm = '0;
                pend.delete();
            end
            f_r    = in_instr[31];
            f_rs   = int'((in_instr >> 25) & 32'h3F);
            f_rd   = int'((in_instr >> 19) & 32'h3F);
            f_func = int'((in_instr >> 15) & 32'hF);
            f_rt   = int'((in_instr >> 9) & 32'h3F);
            f_imm  = in_instr[14] ? ((in_instr & 32'h7FFF) | 32'hFFFF_8000) : (in_instr & 32'h7FFF);
            f_we   = !write_disable && (f_rd != 0);
            c_pop  = SB_EN && wb_valid && (pend.size() > 0);
            c_haz  = SB_EN && in_valid &&
                     (pending_hit(f_rs, c_pop) || (f_r && pending_hit(f_rt, c_pop)) ||
                      (f_we && pend.size() == 4 && !wb_valid));
            c_rdy  = (!m_valid || out_ready) && !c_haz;

            chk("out_valid", 32'(out_valid), 32'(m_valid));
            chk("out_r", 32'(out_r), 32'(m_r));
            chk("out_rs", 32'(out_rs), 32'(m_rs));
            chk("out_rd", 32'(out_rd), 32'(m_rd));
            chk("out_rt", 32'(out_rt), 32'(m_rt));
            chk("out_func", 32'(out_func), 32'(m_func));
            chk("out_imm", out_imm, m_imm);
            chk("out_write_en", 32'(out_write_en), 32'(m_we));
            chk("hazard", 32'(hazard), 32'(c_haz));
            chk("in_ready", 32'(in_ready), 32'(c_rdy));
            $display("cyc t=%0t in_v=%0b instr=%08h wd=%0b wb=%0b out_v=%0b rd=%0d haz=%0b rdy=%0b pend=%0d",
                     $time, in_valid, in_instr, write_disable, wb_valid, out_valid, out_rd,
                     hazard, in_ready, pend.size());

            if (!rst) begin
                if (c_pop) void'(pend.pop_front());
                if (in_valid && c_rdy) begin
                    m_valid = 1; m_r = f_r; m_rs = f_rs; m_rd = f_rd; m_rt = f_rt;
                    m_func = f_func; m_imm = f_imm; m_we = f_we;
                    if (SB_EN && f_we) pend.push_back(f_rd);
                end else if (out_ready) begin
                    m_valid = 0;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1; in_valid = 0; in_instr = '0; write_disable = 0; out_ready = 1; wb_valid = 0;
        repeat (2) @(posedge clk);
        #1 rst = 0;
        #1;
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset in_ready", 32'(in_ready), 32'd1);
        chk("reset hazard", 32'(hazard), 32'd0);

        // R-type decode
        in_valid = 1; in_instr = 32'h8A4C_9600;
        step();
        in_valid = 0;
        chk("rtype out_r", 32'(out_r), 32'd1);
        chk("rtype out_rs", 32'(out_rs), 32'd5);
        chk("rtype out_rd", 32'(out_rd), 32'd9);
        chk("rtype out_func", 32'(out_func), 32'd9);
        chk("rtype out_rt", 32'(out_rt), 32'd11);
        chk("rtype out_imm", out_imm, 32'h0000_1600);
        chk("rtype out_write_en", 32'(out_write_en), 32'd1);

        // I-type, negative immediate, write suppressed
        in_valid = 1; write_disable = 1;
        in_instr = (32'd3 << 25) | (32'd4 << 19) | 32'h4001;
        step();
        in_valid = 0; write_disable = 0;
        chk("itype out_imm", out_imm, 32'hFFFF_C001);
        chk("itype out_write_en", 32'(out_write_en), 32'd0);

        // R-type reading rt=9 while rd=9 is pending
        in_valid = 1;
        in_instr = 32'h8000_0000 | (32'd1 << 25) | (32'd2 << 19) | (32'd9 << 9);
        #1;
        chk("raw hazard", 32'(hazard), 32'(SB_EN));
        chk("raw in_ready", 32'(in_ready), 32'(!SB_EN));
        if (SB_EN) begin
            step();
            chk("raw hazard held", 32'(hazard), 32'd1);
            wb_valid = 1;
            #1;
            chk("raw released", 32'(in_ready), 32'd1);
        end
        step();
        in_valid = 0; wb_valid = 0;
        chk("raw accepted rd", 32'(out_rd), 32'd2);
        wb_valid = 1;
        step();
        wb_valid = 0;

        // Four writers fill the scoreboard
        for (int k = 0; k < 4; k++) begin
            in_valid = 1; in_instr = 32'(10 + k) << 19;
            step();
        end
        in_instr = 32'd14 << 19;
        #1;
        chk("full hazard", 32'(hazard), 32'(SB_EN));
        wb_valid = 1;
        #1;
        chk("full with wb hazard", 32'(hazard), 32'd0);
        chk("full with wb in_ready", 32'(in_ready), 32'd1);
        step();
        wb_valid = 0; in_instr = 32'd15 << 19;
        #1;
        chk("still full hazard", 32'(hazard), 32'(SB_EN));
        in_valid = 0; wb_valid = 1;
        repeat (4) step();
        wb_valid = 0;

        // Downstream stall, then reset mid-stall
        out_ready = 0; in_valid = 1; in_instr = 32'd20 << 19;
        step();
        in_instr = 32'd21 << 19;
        for (int k = 0; k < 3; k++) begin
            chk("stall in_ready", 32'(in_ready), 32'd0);
            chk("stall out_rd", 32'(out_rd), 32'd20);
            step();
        end
        chk("stall out_valid", 32'(out_valid), 32'd1);
        rst = 1;
        #1;
        chk("async rst out_valid", 32'(out_valid), 32'd0);
        chk("async rst out_rd", 32'(out_rd), 32'd0);
        step();
        rst = 0; out_ready = 1;
        in_instr = 32'd20 << 25;
        #1;
        chk("post rst no hazard", 32'(hazard), 32'd0);
        chk("post rst in_ready", 32'(in_ready), 32'd1);
        step();
        in_valid = 0;
        repeat (2) step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
# decode_stage

Registered, parametrised instruction-decode stage for the single-cycle MIPS-style core, replacing the purely combinational field splitter. It sits between instruction fetch and the register file/ALU and adds a valid/ready handshake on both sides and a write-enable gate. An in-order scoreboard of pending register writes stalls any instruction whose sources are still being written.

## Interface
Parameters:
- INSTR_W, 32, instruction width; must equal 1 + 2*REG_AW + FUNC_W + IMM_W
- REG_AW, 6, register-address width
- FUNC_W, 4, function-code width
- IMM_W, 15, immediate field width
- DATA_W, 32, width of the sign-extended immediate output
- SB_DEPTH, 4, pending-write scoreboard entries (power of two, ≥2)

Ports:
- clk  in  1  clock; all state on rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  fetch presents an instruction
- in_ready  out  1  stage accepts this cycle
- in_instr  in  INSTR_W  instruction word
- write_disable  in  1  sampled with in_instr; forces out_write_en=0 for that instruction
- out_valid  out  1  decoded instruction held
- out_ready  in  1  downstream consumes
- out_r  out  1  R-type flag, in_instr[INSTR_W-1]
- out_rs  out  REG_AW  next REG_AW bits below out_r
- out_rd  out  REG_AW  next REG_AW bits below rs
- out_func  out  FUNC_W  next FUNC_W bits below rd
- out_rt  out  REG_AW  in_instr[IMM_W-1 -: REG_AW]
- out_imm  out  DATA_W  in_instr[IMM_W-1:0], sign-extended
- out_write_en  out  1  instruction writes out_rd
- wb_valid  in  1  oldest pending write retires
- hazard  out  1  valid input blocked by scoreboard match or full

## Operation
- Output register: loads on accept (in_valid && in_ready); out_valid clears on out_valid && out_ready with no accept that cycle.
- write_en = !write_disable && out_rd != 0 (register 0 is hardwired).
- Sources: R-type reads rs and rt; I-type (r=0) reads rs only. Source 0 never hazards.
- Scoreboard: FIFO of SB_DEPTH rd values. Push on accept when write_en=1. Pop head on wb_valid; wb_valid with empty scoreboard is ignored.
- hazard = in_valid && (source matches any valid entry remaining after this cycle's pop, or (write_en && scoreboard full && !wb_valid)).
- in_ready = (!out_valid || out_ready) && !hazard.
- Same-cycle push and pop: count unchanged, legal when full.
- Widths: default field layout is r[31], rs[30:25], rd[24:19], func[18:15], rt[14:9], imm[14:0]; rt and imm overlap by design.

## Timing
- Latency 1 cycle: accept at edge N, out_valid high after edge N; throughput 1/cycle with out_ready held high.
- Reset: out_valid=0, out_r/rs/rd/rt/func/imm=0, out_write_en=0, scoreboard empty; hazard and in_ready are combinational (in_ready=1 with in_valid=0 after reset).
- Reset mid-operation discards the held instruction and all pending entries immediately.
- Outputs are stable while out_valid && !out_ready.
- A wb_valid releases a matching hazard in the same cycle: the instruction is accepted at that edge.

## Configuration
- DECODE_SCOREBOARD_EN defined: scoreboard, hazard detection and wb_valid behave as above.
- Not defined: no scoreboard storage; hazard tied 0; wb_valid ignored; in_ready = !out_valid || out_ready.

## Structure
- decode_pkg: default width constants, field-offset localparams, decoded_instr_t struct (r, rs, rd, rt, func, imm, write_en), extraction function.
- Sub-module decode_scoreboard: FIFO with push/pop, full/empty, and two-source parallel match outputs. Instantiated only under DECODE_SCOREBOARD_EN.

## Test plan
- Reset then in_instr=0x8A4C_9600 (R-type, rs=5, rd=9, func=9, rt=11), write_disable=0, out_ready=1 -> next cycle out_r=1, out_rs=5, out_rd=9, out_func=9, out_rt=11, out_write_en=1.
- I-type with imm=0x4001 -> out_imm=0xFFFF_C001; with write_disable=1 -> out_write_en=0 and scoreboard count unchanged.
- Issue a write to rd=9, then an R-type reading rt=9 -> hazard=1, in_ready=0; pulse wb_valid -> accepted that same edge.
- Fill four writes with no wb_valid, fifth writer -> hazard=1; assert wb_valid in the same cycle -> accepted, count stays 4.
- out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, outputs held constant; rst asserted mid-stall -> out_valid=0 and scoreboard empty asynchronously.
- Build without DECODE_SCOREBOARD_EN and rerun the hazard case -> no stall, back-to-back accepts.
